// File: rtl/s2mm_stream_burst_writer.sv
// S2MM datapath: drains an AXI4-Stream into memory as INCR bursts on an AXI4 master port.
// Optional TLAST checking is compiled in with the S2MM_TLAST_CHECK_EN macro.
module s2mm_stream_burst_writer #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_BURST_LEN        = 8,
    parameter int unsigned C_LEN_WIDTH        = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,

    input  logic                              cfg_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cfg_base_addr,
    input  logic [C_LEN_WIDTH-1:0]            cfg_num_beats,
    output logic                              sts_busy,
    output logic                              sts_done,
    output logic                              sts_error,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam int unsigned AW        = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW        = C_M_AXI_DATA_WIDTH;
    localparam int unsigned LW        = C_LEN_WIDTH;
    localparam int unsigned SW        = DW / 8;
    localparam int unsigned SizeLog   = $clog2(SW);
    localparam int unsigned AlignBits = $clog2(C_BURST_LEN * SW);
    localparam int unsigned BW        = $clog2(C_BURST_LEN) + 1;

    // Aligning the base to a full burst keeps every burst inside one 4KB page.
    localparam logic [AW-1:0] AlignMask = ~((AW'(1) << AlignBits) - AW'(1));

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StResp,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [BW-1:0]   burst_beats;
    logic [LW-1:0]   rem_after;
    logic [AW-1:0]   addr_after;
    logic            in_addr;
    logic            in_data;
    logic            last_beat;
    logic            w_hs;

    always_comb begin
        burst_beats = (rem_q >= LW'(C_BURST_LEN)) ? BW'(C_BURST_LEN) : rem_q[BW-1:0];
        rem_after   = rem_q - LW'(burst_beats);
        addr_after  = addr_q + (AW'(burst_beats) << SizeLog);
        in_addr     = (state_q == StAddr);
        in_data     = (state_q == StData);
        last_beat   = (beat_q == (burst_beats - BW'(1)));
        w_hs        = in_data && S_AXIS_TVALID && M_AXI_WREADY;
    end

    // Outputs are gated by state so that everything reads 0 outside its phase.
    always_comb begin
        M_AXI_AWVALID = in_addr;
        M_AXI_AWADDR  = in_addr ? addr_q : '0;
        M_AXI_AWLEN   = in_addr ? (8'(burst_beats) - 8'd1) : 8'd0;
        M_AXI_AWSIZE  = in_addr ? 3'(SizeLog) : 3'd0;
        M_AXI_AWBURST = in_addr ? 2'b01 : 2'b00;
        M_AXI_WVALID  = in_data && S_AXIS_TVALID;
        M_AXI_WDATA   = in_data ? S_AXIS_TDATA : '0;
        M_AXI_WSTRB   = in_data ? '1 : '0;
        M_AXI_WLAST   = in_data && last_beat;
        S_AXIS_TREADY = in_data && M_AXI_WREADY;
        M_AXI_BREADY  = (state_q == StResp);
        sts_busy      = busy_q;
        sts_done      = done_q;
        sts_error     = err_q;
    end

`ifndef S2MM_TLAST_CHECK_EN
    logic unused_tlast;
    assign unused_tlast = S_AXIS_TLAST;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    addr_d  = cfg_base_addr & AlignMask;
                    rem_d   = cfg_num_beats;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (cfg_num_beats == '0) ? StDone : StAddr;
                end
            end
            StAddr: begin
                if (M_AXI_AWREADY) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (w_hs) begin
`ifdef S2MM_TLAST_CHECK_EN
                    // TLAST must mark exactly the final beat of the whole transfer.
                    if (S_AXIS_TLAST != (last_beat && (rem_q == LW'(burst_beats)))) begin
                        err_d = 1'b1;
                    end
`endif
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = StResp;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                    end
                end
            end
            StResp: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        err_d = 1'b1;
                    end
                    rem_d   = rem_after;
                    addr_d  = addr_after;
                    state_d = (rem_after != '0) ? StAddr : StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
